// File: rtl/mmul_pkg.sv
// Shared defaults, FSM encoding and output-length formula for the mmul host
// driver and the accelerator it feeds.
package mmul_pkg;

  localparam int DEF_ORDER  = 64;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_PUSH   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Words the accelerator emits on fC per job: N*N results plus two framing words.
  function automatic int out_words(input int order);
    return order * order + 2;
  endfunction

endpackage

// File: rtl/driver_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// A same-address write and read in one cycle returns the old data.
module driver_sdp_ram
  import mmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mmul_host_driver.sv
// Streams operand RAMs A/B in lockstep into the accelerator, pulses START,
// then drains fC into a result RAM, dropping words outside the result window.
module mmul_host_driver
  import mmul_pkg::*;
#(
  parameter int ORDER        = DEF_ORDER,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int OUT_WORDS    = out_words(ORDER),
  parameter int LEAD_DISCARD = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              GO,
  output logic              Busy,
  output logic              Done,
  input  logic              ld_enable,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              START,
  input  logic              fA_write_ready,
  output logic              fA_write_enable,
  output logic [DATA_W-1:0] fA_write_data,
  input  logic              fB_write_ready,
  output logic              fB_write_enable,
  output logic [DATA_W-1:0] fB_write_data,
  input  logic              fC_read_ready,
  output logic              fC_read_enable,
  input  logic [DATA_W-1:0] fC_read_data
);

  localparam int CW  = ADDR_W + 1;
  localparam int NSQ = ORDER * ORDER;
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] LAST_P = CW'(NSQ - 1);
  localparam logic [CW-1:0] LAST_Q = CW'(OUT_WORDS - 1);
  localparam logic [CW-1:0] WIN_LO = CW'(LEAD_DISCARD);
  localparam logic [CW-1:0] WIN_HI = CW'(LEAD_DISCARD + NSQ);

  state_e            state_q, state_d;
  logic [CW-1:0]     p_q, p_d, q_q, q_d, rd_ptr_q, rd_ptr_d;
  logic              stg_vld_q, stg_vld_d, done_q, done_d;
  logic [DATA_W-1:0] stg_a_q, stg_a_d, stg_b_q, stg_b_d;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              busy, push, pop, ld_we, res_we;
  logic [ADDR_W-1:0] src_raddr, res_waddr;

  assign busy   = (state_q == ST_PRIME) || (state_q == ST_PUSH) || (state_q == ST_DRAIN);
  assign push   = (state_q == ST_PUSH) && stg_vld_q && fA_write_ready && fB_write_ready;
  assign pop    = (state_q == ST_DRAIN) && fC_read_ready;
  assign ld_we  = ld_enable && !busy;
  assign res_we = pop && (q_q >= WIN_LO) && (q_q < WIN_HI);

  // rd_ptr_q is the element the RAM output currently holds; on a push the
  // following element is requested so staging can refill every cycle.
  assign src_raddr = (state_q == ST_IDLE) ? '0 : ADDR_W'(push ? rd_ptr_q + ONE : rd_ptr_q);
  assign res_waddr = ADDR_W'(q_q - WIN_LO);

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    rd_ptr_d  = rd_ptr_q;
    stg_vld_d = stg_vld_q;
    stg_a_d   = stg_a_q;
    stg_b_d   = stg_b_q;
    done_d    = done_q;
    case (state_q)
      ST_IDLE: begin
        if (GO) begin
          done_d    = 1'b0;
          p_d       = '0;
          q_d       = '0;
          rd_ptr_d  = ONE;
          stg_vld_d = 1'b0;
          state_d   = ST_PRIME;
        end
      end
      ST_PRIME: begin
        stg_vld_d = 1'b1;
        stg_a_d   = a_rdata;
        stg_b_d   = b_rdata;
        state_d   = ST_PUSH;
      end
      ST_PUSH: begin
        if (push) begin
          stg_a_d  = a_rdata;
          stg_b_d  = b_rdata;
          rd_ptr_d = rd_ptr_q + ONE;
          p_d      = p_q + ONE;
          if (p_q == LAST_P) begin
            stg_vld_d = 1'b0;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop) begin
          q_d = q_q + ONE;
          if (q_q == LAST_Q) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      p_q       <= '0;
      q_q       <= '0;
      rd_ptr_q  <= '0;
      stg_vld_q <= 1'b0;
      stg_a_q   <= '0;
      stg_b_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      q_q       <= q_d;
      rd_ptr_q  <= rd_ptr_d;
      stg_vld_q <= stg_vld_d;
      stg_a_q   <= stg_a_d;
      stg_b_q   <= stg_b_d;
      done_q    <= done_d;
    end
  end

  assign Busy            = busy;
  assign Done            = done_q || (state_q == ST_FINISH);
  assign START           = (state_q == ST_PRIME);
  assign fA_write_enable = push;
  assign fB_write_enable = push;
  assign fA_write_data   = stg_a_q;
  assign fB_write_data   = stg_b_q;
  assign fC_read_enable  = pop;

  driver_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_a (
    .clk_i(CLK), .rst_i(RST), .we_i(ld_we && !ld_sel), .waddr_i(ld_addr),
    .wdata_i(ld_data), .raddr_i(src_raddr), .rdata_o(a_rdata)
  );

  driver_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_b (
    .clk_i(CLK), .rst_i(RST), .we_i(ld_we && ld_sel), .waddr_i(ld_addr),
    .wdata_i(ld_data), .raddr_i(src_raddr), .rdata_o(b_rdata)
  );

  driver_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_c (
    .clk_i(CLK), .rst_i(RST), .we_i(res_we), .waddr_i(res_waddr),
    .wdata_i(fC_read_data), .raddr_i(rd_addr), .rdata_o(rd_data)
  );

endmodule

// File: doc/mmul_host_driver.md
Name: mmul_host_driver

Overview:
- Host-side counterpart of the matrix-multiply accelerator. Holds operand matrices A and B in local RAMs and streams them, row-major, into the accelerator's fA/fB write ports.
- Pulses the accelerator START, then drains the fC read port into a local result RAM.
- Serves as the stimulus/collection end of the mmul datapath, both on-chip and in system-level benches.

Parameters:
- ORDER, 64, matrix dimension N (N x N operands).
- DATA_W, 32, element width.
- ADDR_W, 12, local RAM address width; must satisfy 2**ADDR_W >= ORDER**2.
- OUT_WORDS, ORDER**2+2, total words the accelerator emits on fC per job.
- LEAD_DISCARD, 1, leading fC words dropped before storing results.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- GO  in  1  job request; sampled only in IDLE.
- Busy  out  1  high from GO acceptance until Done.
- Done  out  1  level; set on job completion, cleared by the next accepted GO or by RST.
- ld_enable  in  1  host write strobe into source RAMs.
- ld_sel  in  1  0 selects A RAM, 1 selects B RAM.
- ld_addr  in  ADDR_W  source RAM write address.
- ld_data  in  DATA_W  source RAM write data.
- rd_addr  in  ADDR_W  result RAM read address.
- rd_data  out  DATA_W  result RAM data, 1-cycle latency.
- START  out  1  one-cycle pulse to the accelerator.
- fA_write_ready  in  1  accelerator fA can accept a word.
- fA_write_enable  out  1  push strobe into fA.
- fA_write_data  out  DATA_W  word pushed into fA.
- fB_write_ready  in  1  accelerator fB can accept a word.
- fB_write_enable  out  1  push strobe into fB.
- fB_write_data  out  DATA_W  word pushed into fB.
- fC_read_ready  in  1  fC holds a valid word.
- fC_read_enable  out  1  pop strobe from fC.
- fC_read_data  in  DATA_W  fC head word (first-word fall-through; valid while fC_read_ready).

Behaviour:
- Reset values: Busy=0, Done=0, START=0, all enables 0, write data 0, rd_data 0. All counters 0. State IDLE.
- A reset mid-job aborts immediately to IDLE. RAM contents are not cleared.
- Handshakes:
  - A push completes in a cycle where enable=1 and ready=1.
  - A and B are pushed in lockstep: both enables assert together, only when fA_write_ready && fB_write_ready && the staged pair is valid.
  - fC pop completes when fC_read_enable && fC_read_ready. fC_read_enable = fC_read_ready while in DRAIN.
  - Enables never assert when the corresponding ready=0.
- Source RAM reads have 1-cycle latency. A one-entry staging register per stream (valid bit + data) hides that latency:
  - On a push, the next address is already in flight, so back-to-back pushes sustain 1 word/cycle.
  - When a push stalls, the staging register holds and no new read is issued.
- States:
  - IDLE: Busy=0. On GO, clear Done and counters, issue read of address 0, go to PRIME.
  - PRIME: load staging with element 0, pulse START for this single cycle, go to PUSH.
  - PUSH: push counter p counts 0..N²-1. After the push with p=N²-1, go to DRAIN. No fC pops occur in PUSH.
  - DRAIN: receive counter q counts 0..OUT_WORDS-1.
    - Word q is written to result RAM at address q-LEAD_DISCARD, only when LEAD_DISCARD <= q < LEAD_DISCARD+N².
    - Words outside that window are popped and dropped.
    - After pop q=OUT_WORDS-1, go to FINISH.
  - FINISH: set Done=1 and Busy=0, return to IDLE in the same cycle.
- GO asserted outside IDLE is ignored. ld_enable during Busy is ignored, which protects operands.
- A result RAM write and a host rd_addr read in the same cycle to the same address return the old data.
- Counters are ADDR_W+1 bits wide, so N²+2 does not wrap.
- No timeout: a stalled accelerator holds the block in PUSH or DRAIN until RST.

Decomposition:
- Shared package mmul_pkg holds:
  - ORDER, DATA_W, ADDR_W defaults;
  - the state enum {IDLE, PRIME, PUSH, DRAIN, FINISH};
  - the OUT_WORDS formula, shared with the accelerator.
- One sub-module, driver_sdp_ram: simple dual-port RAM, 1 write port, 1 registered read port. Instantiated three times (A source, B source, result).

Test Plan:
- ORDER=4, load A=identity and B[k]=k+1, GO, accelerator model always ready. Required:
  - START pulse exactly 1 cycle after GO;
  - 16 lockstep pushes on consecutive cycles, fA data 1,0,0,0,0,1,... and fB data 1..16;
  - DRAIN stores result RAM [0..15] equal to 1..16;
  - Done=1, Busy=0.
- Backpressure: toggle fA_write_ready every cycle with fB_write_ready=1. Required:
  - no enable ever asserts while fA_write_ready=0;
  - sequence order preserved, 16 pushes total, no duplicates or drops.
- fC gaps: fC_read_ready follows a 1-on, 3-off pattern over 18 words (word 0 = 0xDEAD). Required:
  - 0xDEAD is discarded (LEAD_DISCARD=1);
  - words 1..16 land at addresses 0..15;
  - word 17 is dropped;
  - Done rises only after the 18th pop.
- Assert RST mid-PUSH (p=7). Required:
  - next cycle all outputs are at reset values and state is IDLE;
  - a new GO restarts from p=0 and completes correctly.
- GO during DRAIN and ld_enable during Busy (writing 0xFFFF_FFFF to A[0]). Required:
  - both ignored;
  - after Done, rd_addr=0 returns the unchanged result and the A RAM still holds its original value.
